// File: rtl/wb_stream_writer_dma.sv
// Wishbone B3 read master that streams a circular or one-shot buffer into a write FIFO.
// Define WB_STREAM_WRITER_DMA_TIMEOUT_EN to add the BURST stall watchdog and the timeout_o port.
module wb_stream_writer_dma #(
    parameter int WB_AW          = 32,
    parameter int WB_DW          = 32,
    parameter int FIFO_AW        = 4,
    parameter int MAX_BURST_LEN  = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    output logic [WB_AW-1:0]               wbm_adr_o,
    output logic [WB_DW-1:0]               wbm_dat_o,
    output logic [WB_DW/8-1:0]             wbm_sel_o,
    output logic                           wbm_we_o,
    output logic                           wbm_cyc_o,
    output logic                           wbm_stb_o,
    output logic [2:0]                     wbm_cti_o,
    output logic [1:0]                     wbm_bte_o,
    input  logic [WB_DW-1:0]               wbm_dat_i,
    input  logic                           wbm_ack_i,
    input  logic                           wbm_err_i,
    input  logic                           wbm_rty_i,
    output logic [WB_DW-1:0]               fifo_d,
    output logic                           fifo_wr,
    input  logic [FIFO_AW:0]               fifo_cnt,
    input  logic                           enable,
    input  logic                           oneshot,
    input  logic [WB_AW-1:0]               start_adr,
    input  logic [WB_AW-1:0]               buf_size,
    input  logic [$clog2(MAX_BURST_LEN):0] burst_size,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           err_o,
    output logic [WB_AW-1:0]               cur_adr_o
`ifdef WB_STREAM_WRITER_DMA_TIMEOUT_EN
    ,
    output logic                           timeout_o
`endif
);

    localparam int BPW      = WB_DW / 8;
    localparam int BPW_LOG2 = $clog2(BPW);
    localparam int BSW      = $clog2(MAX_BURST_LEN) + 1;
    localparam int CW       = (FIFO_AW + 2 > BSW + 1) ? FIFO_AW + 2 : BSW + 1;

    if (FIFO_AW < 1) begin : g_bad_fifo_aw
        $error("wb_stream_writer_dma: FIFO_AW must be > 0");
    end
    if (WB_DW < 8 || (WB_DW & (WB_DW - 1)) != 0) begin : g_bad_wb_dw
        $error("wb_stream_writer_dma: WB_DW must be a power of 2 and >= 8");
    end
    if (MAX_BURST_LEN < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_limits
        $error("wb_stream_writer_dma: MAX_BURST_LEN and TIMEOUT_CYCLES must be >= 1");
    end

    // IDLE: stopped | WAIT: cyc low, waiting for FIFO room | BURST: bus cycle | ERROR: hold until enable drops
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_ERROR} state_t;

    state_t           state_q, state_d;
    logic [WB_AW-1:0] idx_q, idx_d;
    logic [WB_AW-1:0] nw_q, nw_d;
    logic [WB_AW-1:0] base_q, base_d;
    logic [BSW-1:0]   beat_q, beat_d;
    logic [BSW-1:0]   blen_q, blen_d;
    logic             oneshot_q, oneshot_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    logic [WB_AW-1:0] remain;
    logic [BSW-1:0]   blen_calc;
    logic [CW-1:0]    fill_sum;
    logic             room_ok;
    logic             last_beat;
    logic             idx_last;
    logic             to_hit;

    always_comb begin
        remain    = nw_q - idx_q;
        blen_calc = burst_size;
        if (remain < WB_AW'(burst_size)) begin
            blen_calc = BSW'(remain);
        end
        fill_sum  = CW'(fifo_cnt) + CW'(blen_calc);
        room_ok   = fill_sum <= (CW'(1) << FIFO_AW);
        last_beat = beat_q == (blen_q - BSW'(1));
        idx_last  = idx_q == (nw_q - WB_AW'(1));
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        nw_d      = nw_q;
        base_d    = base_q;
        beat_d    = beat_q;
        blen_d    = blen_q;
        oneshot_d = oneshot_q;
        err_d     = err_q;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable && !err_q) begin
                    state_d   = S_WAIT;
                    idx_d     = '0;
                    base_d    = start_adr;
                    nw_d      = buf_size >> BPW_LOG2;
                    oneshot_d = oneshot;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (room_ok) begin
                    state_d = S_BURST;
                    blen_d  = blen_calc;
                    beat_d  = '0;
                end
            end
            S_BURST: begin
                if (wbm_err_i || to_hit) begin
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else if (wbm_rty_i) begin
                    state_d = S_WAIT;
                    beat_d  = '0;
                end else if (wbm_ack_i) begin
                    idx_d  = idx_last ? '0 : idx_q + WB_AW'(1);
                    beat_d = beat_q + BSW'(1);
                    if (last_beat) begin
                        beat_d = '0;
                        if (idx_last && oneshot_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else if (!enable) begin
                            state_d = S_IDLE;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end
                end
            end
            S_ERROR: begin
                if (!enable) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            nw_q      <= '0;
            base_q    <= '0;
            beat_q    <= '0;
            blen_q    <= '0;
            oneshot_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            nw_q      <= nw_d;
            base_q    <= base_d;
            beat_q    <= beat_d;
            blen_q    <= blen_d;
            oneshot_q <= oneshot_d;
            err_q     <= err_d;
            done_q    <= done_d;
        end
    end

`ifdef WB_STREAM_WRITER_DMA_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          timeout_q, timeout_d;
    logic          any_term;

    assign any_term = wbm_ack_i | wbm_err_i | wbm_rty_i;
    assign to_hit   = (state_q == S_BURST) && (to_cnt_q == '0) && !any_term;

    // Down-counter reloads outside BURST and on every slave termination.
    always_comb begin
        to_cnt_d  = to_cnt_q - TW'(1);
        timeout_d = timeout_q;
        if (state_q != S_BURST || any_term) begin
            to_cnt_d = TW'(TIMEOUT_CYCLES - 1);
        end
        if (to_hit) begin
            timeout_d = 1'b1;
        end else if (state_q == S_ERROR && !enable) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            to_cnt_q  <= TW'(TIMEOUT_CYCLES - 1);
            timeout_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign to_hit = 1'b0;
`endif

    assign wbm_adr_o = base_q + (idx_q << BPW_LOG2);
    assign wbm_dat_o = '0;
    assign wbm_sel_o = '1;
    assign wbm_we_o  = 1'b0;
    assign wbm_cyc_o = state_q == S_BURST;
    assign wbm_stb_o = state_q == S_BURST;
    assign wbm_cti_o = (state_q != S_BURST) ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
    assign wbm_bte_o = 2'b00;
    assign fifo_d    = wbm_dat_i;
    assign fifo_wr   = wbm_ack_i & wbm_cyc_o;
    assign busy_o    = state_q != S_IDLE;
    assign done_o    = done_q;
    assign err_o     = err_q;
    assign cur_adr_o = wbm_adr_o;

endmodule

// File: tb/tb_wb_stream_writer_dma.sv
// Directed bench for wb_stream_writer_dma: 32-bit instance for most scenarios, 64-bit instance for width and reset.
module tb_wb_stream_writer_dma;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        rst_n;
    logic        enable, oneshot;
    logic [31:0] start_adr, buf_size;
    logic [4:0]  burst_size;
    logic [4:0]  fifo_cnt;
    logic        ack_en, rty_now, err_now;

    logic [31:0] adr, dat_o, dat_i, fifo_d, cur_adr;
    logic [3:0]  sel;
    logic        we, cyc, stb, ack, err, rty, fifo_wr, busy, done, err_o;
    logic [2:0]  cti;
    logic [1:0]  bte;

    logic [31:0] adr64, cur64;
    logic [63:0] dat_o64, dat_i64, fifo_d64;
    logic [7:0]  sel64;
    logic        we64, cyc64, stb64, ack64, err64, rty64, fifo_wr64, busy64, done64, erro64, en64;
    logic [2:0]  cti64;
    logic [1:0]  bte64;
    logic [4:0]  fifo_cnt64;

`ifdef WB_STREAM_WRITER_DMA_TIMEOUT_EN
    logic timeout, timeout64;
`endif

    assign ack     = cyc & stb & ack_en & !rty_now & !err_now;
    assign rty     = cyc & stb & rty_now;
    assign err     = cyc & stb & err_now;
    assign dat_i   = {16'hA5A5, adr[15:0]};
    assign ack64   = cyc64 & stb64;
    assign rty64   = 1'b0;
    assign err64   = 1'b0;
    assign dat_i64 = {32'h5A5A_0000, adr64};

    wb_stream_writer_dma #(.WB_AW(32), .WB_DW(32), .FIFO_AW(4), .MAX_BURST_LEN(16), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbm_adr_o(adr), .wbm_dat_o(dat_o), .wbm_sel_o(sel), .wbm_we_o(we),
        .wbm_cyc_o(cyc), .wbm_stb_o(stb), .wbm_cti_o(cti), .wbm_bte_o(bte),
        .wbm_dat_i(dat_i), .wbm_ack_i(ack), .wbm_err_i(err), .wbm_rty_i(rty),
        .fifo_d(fifo_d), .fifo_wr(fifo_wr), .fifo_cnt(fifo_cnt),
        .enable(enable), .oneshot(oneshot), .start_adr(start_adr), .buf_size(buf_size),
        .burst_size(burst_size), .busy_o(busy), .done_o(done), .err_o(err_o), .cur_adr_o(cur_adr)
`ifdef WB_STREAM_WRITER_DMA_TIMEOUT_EN
        , .timeout_o(timeout)
`endif
    );

    wb_stream_writer_dma #(.WB_AW(32), .WB_DW(64), .FIFO_AW(4), .MAX_BURST_LEN(16), .TIMEOUT_CYCLES(8)) dut64 (
        .wb_clk_i(clk), .wb_rst_i(rst_n),
        .wbm_adr_o(adr64), .wbm_dat_o(dat_o64), .wbm_sel_o(sel64), .wbm_we_o(we64),
        .wbm_cyc_o(cyc64), .wbm_stb_o(stb64), .wbm_cti_o(cti64), .wbm_bte_o(bte64),
        .wbm_dat_i(dat_i64), .wbm_ack_i(ack64), .wbm_err_i(err64), .wbm_rty_i(rty64),
        .fifo_d(fifo_d64), .fifo_wr(fifo_wr64), .fifo_cnt(fifo_cnt64),
        .enable(en64), .oneshot(1'b0), .start_adr(32'h0000_8000), .buf_size(32'h0000_0080),
        .burst_size(5'd4), .busy_o(busy64), .done_o(done64), .err_o(erro64), .cur_adr_o(cur64)
`ifdef WB_STREAM_WRITER_DMA_TIMEOUT_EN
        , .timeout_o(timeout64)
`endif
    );

    logic [31:0] adr_q[$];
    logic [2:0]  cti_q[$];
    logic [31:0] dat_q[$];
    logic [31:0] adr64_q[$];
    int          wr_cnt = 0;

    always @(posedge clk) begin
        if (cyc && stb && ack) begin
            adr_q.push_back(adr);
            cti_q.push_back(cti);
            dat_q.push_back(fifo_d);
        end
        if (fifo_wr) wr_cnt <= wr_cnt + 1;
        if (cyc64 && stb64 && ack64) adr64_q.push_back(adr64);
    end

    task automatic clear_log();
        adr_q.delete();
        cti_q.delete();
        dat_q.delete();
        wr_cnt = 0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: busy=%b want 0 after %0d cycles", name, busy, n);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; en64 = 1'b0; oneshot = 1'b0;
        start_adr = 32'h0; buf_size = 32'h40; burst_size = 5'd4; fifo_cnt = 5'd0; fifo_cnt64 = 5'd0;
        ack_en = 1'b1; rty_now = 1'b0; err_now = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (cyc !== 1'b0)   begin bad++; $display("FAIL rst_cyc: got %b want 0", cyc); end
        total++; if (busy !== 1'b0)  begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err_o); end
        total++; if (done !== 1'b0)  begin bad++; $display("FAIL rst_done: got %b want 0", done); end
        total++; if (adr !== 32'h0)  begin bad++; $display("FAIL rst_adr: got %h want 0", adr); end
        total++; if ({we, sel, bte, dat_o} !== {1'b0, 4'hF, 2'b00, 32'h0})
            begin bad++; $display("FAIL rst_ties: got we=%b sel=%h bte=%b dat=%h", we, sel, bte, dat_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_continuous();
        int n = 0;
        clear_log();
        start_adr = 32'h1000; buf_size = 32'h40; burst_size = 5'd4; oneshot = 1'b0; fifo_cnt = 5'd0;
        enable = 1'b1;
        while (adr_q.size() < 20 && n < 300) begin
            @(negedge clk);
            n++;
        end
        enable = 1'b0;
        wait_idle("cont");
        total++;
        if (adr_q.size() != 20) begin
            bad++; $display("FAIL cont_beats: got %0d want 20", adr_q.size());
        end else begin
            for (int i = 0; i < 20; i++) begin
                total++;
                if (adr_q[i] !== 32'h1000 + 32'(i % 16) * 4) begin
                    bad++; $display("FAIL cont_adr[%0d]: got %h want %h", i, adr_q[i], 32'h1000 + 32'(i % 16) * 4);
                end
                total++;
                if (cti_q[i] !== ((i % 4 == 3) ? 3'b111 : 3'b010)) begin
                    bad++; $display("FAIL cont_cti[%0d]: got %b want %b", i, cti_q[i], (i % 4 == 3) ? 3'b111 : 3'b010);
                end
            end
            total++;
            if (dat_q[5] !== 32'hA5A5_1014) begin bad++; $display("FAIL cont_data: got %h want a5a51014", dat_q[5]); end
        end
        total++;
        if (wr_cnt != 20) begin bad++; $display("FAIL cont_fifo_wr: got %0d want 20", wr_cnt); end
    endtask

    task automatic test_oneshot();
        int done_cnt = 0;
        int busy_after = 0;
        logic [31:0] exp_adr [6] = '{32'h2000, 32'h2004, 32'h2008, 32'h200C, 32'h2010, 32'h2014};
        logic [2:0]  exp_cti [6] = '{3'b010, 3'b010, 3'b010, 3'b111, 3'b010, 3'b111};
        clear_log();
        start_adr = 32'h2000; buf_size = 32'h18; burst_size = 5'd4; oneshot = 1'b1;
        enable = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                enable = 1'b0;
            end
            if (done_cnt > 0 && busy !== 1'b0) busy_after++;
        end
        enable = 1'b0;
        oneshot = 1'b0;
        total++; if (done_cnt != 1)   begin bad++; $display("FAIL os_done_pulse: got %0d cycles want 1", done_cnt); end
        total++; if (busy_after != 0) begin bad++; $display("FAIL os_busy_after: got %0d busy cycles want 0", busy_after); end
        total++;
        if (adr_q.size() != 6) begin
            bad++; $display("FAIL os_beats: got %0d want 6", adr_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                total++;
                if (adr_q[i] !== exp_adr[i] || cti_q[i] !== exp_cti[i]) begin
                    bad++; $display("FAIL os_beat[%0d]: got %h/%b want %h/%b", i, adr_q[i], cti_q[i], exp_adr[i], exp_cti[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int early = 0;
        start_adr = 32'h3000; buf_size = 32'h40; burst_size = 5'd4; fifo_cnt = 5'd13;
        enable = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (cyc !== 1'b0) early++;
        end
        total++; if (early != 0) begin bad++; $display("FAIL bp_hold: cyc high %0d cycles want 0", early); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy: got %b want 1", busy); end
        fifo_cnt = 5'd12;
        @(negedge clk);
        total++; if (cyc !== 1'b1) begin bad++; $display("FAIL bp_release: cyc=%b want 1", cyc); end
        total++; if (adr !== 32'h3000) begin bad++; $display("FAIL bp_adr: got %h want 3000", adr); end
        enable = 1'b0;
        fifo_cnt = 5'd0;
        wait_idle("bp");
    endtask

    task automatic test_retry_error();
        int n = 0;
        clear_log();
        start_adr = 32'h4000; buf_size = 32'h10; burst_size = 5'd4;
        enable = 1'b1;
        while (!(cyc === 1'b1 && adr_q.size() == 2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (adr !== 32'h4008 || cti !== 3'b010) begin
            bad++; $display("FAIL re_beat2: got %h/%b want 4008/010", adr, cti);
        end
        rty_now = 1'b1;
        @(negedge clk);
        rty_now = 1'b0;
        total++; if (cyc !== 1'b0) begin bad++; $display("FAIL re_rty_drop: cyc=%b want 0", cyc); end
        @(negedge clk);
        total++;
        if (cyc !== 1'b1 || adr !== 32'h4008 || cti !== 3'b010) begin
            bad++; $display("FAIL re_reissue0: got cyc=%b %h/%b want 1 4008/010", cyc, adr, cti);
        end
        @(negedge clk);
        total++;
        if (cyc !== 1'b1 || adr !== 32'h400C || cti !== 3'b111) begin
            bad++; $display("FAIL re_reissue1: got cyc=%b %h/%b want 1 400c/111", cyc, adr, cti);
        end
        err_now = 1'b1;
        rty_now = 1'b1;
        @(negedge clk);
        err_now = 1'b0;
        rty_now = 1'b0;
        total++; if (err_o !== 1'b1) begin bad++; $display("FAIL re_err_set: got %b want 1", err_o); end
        total++; if (cyc !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL re_err_state: cyc=%b busy=%b want 0/1", cyc, busy); end
        repeat (3) @(negedge clk);
        total++; if (cyc !== 1'b0 || err_o !== 1'b1) begin bad++; $display("FAIL re_err_hold: cyc=%b err=%b want 0/1", cyc, err_o); end
        total++; if (adr_q.size() != 3) begin bad++; $display("FAIL re_taken: got %0d beats want 3", adr_q.size()); end
        enable = 1'b0;
        @(negedge clk);
        total++; if (err_o !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL re_clear: err=%b busy=%b want 0/0", err_o, busy); end
    endtask

`ifdef WB_STREAM_WRITER_DMA_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        int hi = 0;
        start_adr = 32'h5000; buf_size = 32'h40; burst_size = 5'd4;
        ack_en = 1'b0;
        enable = 1'b1;
        while (cyc !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        while (cyc === 1'b1 && hi < 50) begin
            hi++;
            @(negedge clk);
        end
        total++; if (hi != 8) begin bad++; $display("FAIL to_cycles: cyc high %0d cycles want 8", hi); end
        total++; if (timeout !== 1'b1 || err_o !== 1'b1) begin bad++; $display("FAIL to_flags: timeout=%b err=%b want 1/1", timeout, err_o); end
        enable = 1'b0;
        ack_en = 1'b1;
        @(negedge clk);
        total++; if (timeout !== 1'b0 || err_o !== 1'b0) begin bad++; $display("FAIL to_clear: timeout=%b err=%b want 0/0", timeout, err_o); end
    endtask
`endif

    task automatic test_width_reset();
        int n = 0;
        adr64_q.delete();
        en64 = 1'b1;
        while (adr64_q.size() < 5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (adr64_q.size() < 5) begin
            bad++; $display("FAIL w64_beats: got %0d want 5", adr64_q.size());
        end else begin
            total++; if (adr64_q[0] !== 32'h8000) begin bad++; $display("FAIL w64_adr0: got %h want 8000", adr64_q[0]); end
            total++; if (adr64_q[1] !== 32'h8008) begin bad++; $display("FAIL w64_adr1: got %h want 8008", adr64_q[1]); end
            total++; if (adr64_q[4] !== 32'h8020) begin bad++; $display("FAIL w64_adr4: got %h want 8020", adr64_q[4]); end
        end
        total++; if (cyc64 !== 1'b1) begin bad++; $display("FAIL w64_midburst: cyc=%b want 1", cyc64); end
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (cyc64 !== 1'b0 || busy64 !== 1'b0) begin bad++; $display("FAIL w64_rst: cyc=%b busy=%b want 0/0", cyc64, busy64); end
        total++; if (cur64 !== 32'h0) begin bad++; $display("FAIL w64_rst_adr: got %h want 0", cur64); end
        rst_n = 1'b1;
        adr64_q.delete();
        n = 0;
        while (adr64_q.size() < 1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (adr64_q.size() < 1 || adr64_q[0] !== 32'h8000) begin
            bad++; $display("FAIL w64_restart: beats=%0d want first adr 8000", adr64_q.size());
        end
        en64 = 1'b0;
        n = 0;
        while (busy64 && n < 100) begin
            @(negedge clk);
            n++;
        end
        total++; if (busy64 !== 1'b0) begin bad++; $display("FAIL w64_idle: busy=%b want 0", busy64); end
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_oneshot();
        test_backpressure();
        test_retry_error();
`ifdef WB_STREAM_WRITER_DMA_TIMEOUT_EN
        test_timeout();
`endif
        test_width_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stream_writer_dma.md
Name: wb_stream_writer_dma

Overview:
Wishbone B3 read master that streams a circular or one-shot memory buffer into a downstream write FIFO. It is the next generation of the team's stream writer controller, adding:
- arbitrary data width;
- partial last bursts clipped at the buffer end;
- a one-shot mode with a done pulse;
- retry and error handling with sticky status.
It sits between the system bus and the wb_stream FIFO feeding the stream output.

Parameters:
- WB_AW, 32: address width.
- WB_DW, 32: data width; power of 2, >= 8; BPW = WB_DW/8 bytes per word.
- FIFO_AW, 4: FIFO depth 2**FIFO_AW words; must be > 0; elaboration $error otherwise.
- MAX_BURST_LEN, 16: maximum beats per burst; must be >= 1.
- TIMEOUT_CYCLES, 1024: stall watchdog limit; used only with the optional feature.

Ports:
- wb_clk_i  in  1  clock.
- wb_rst_i  in  1  synchronous reset, active-low.
- wbm_adr_o  out  WB_AW  byte address.
- wbm_dat_o  out  WB_DW  tied 0.
- wbm_sel_o  out  WB_DW/8  all ones.
- wbm_we_o  out  1  tied 0.
- wbm_cyc_o, wbm_stb_o  out  1  bus request.
- wbm_cti_o  out  3  cycle type.
- wbm_bte_o  out  2  tied 2'b00.
- wbm_dat_i  in  WB_DW  read data.
- wbm_ack_i, wbm_err_i, wbm_rty_i  in  1  slave terminations.
- fifo_d  out  WB_DW  = wbm_dat_i.
- fifo_wr  out  1  = wbm_ack_i & wbm_cyc_o.
- fifo_cnt  in  FIFO_AW+1  current FIFO fill, 0..2**FIFO_AW.
- enable  in  1  run request, level.
- oneshot  in  1  1 = stop after one buffer pass; 0 = wrap forever.
- start_adr  in  WB_AW  buffer base; BPW-aligned.
- buf_size  in  WB_AW  buffer length in bytes; multiple of BPW, nonzero.
- burst_size  in  clog2(MAX_BURST_LEN)+1  beats per burst, 1..MAX_BURST_LEN.
- busy_o  out  1  high in any non-IDLE state.
- done_o  out  1  one-cycle pulse at end of a one-shot pass.
- err_o  out  1  sticky bus error flag.
- cur_adr_o  out  WB_AW  = wbm_adr_o.

Behaviour:
Reset (wb_rst_i low at a clock edge):
- state IDLE, word index 0, beat count 0, err_o 0, done_o 0.
- cyc, stb, busy_o are 0 from the following cycle.
- Reset mid-burst abandons the burst with no drain.

Configuration:
- start_adr, buf_size, oneshot are latched on the IDLE->WAIT transition.
- Changes to these inputs while busy are ignored.
- burst_size is sampled each time WAIT issues a burst.

Addressing:
- Word index idx runs 0..NW-1, where NW = buf_size/BPW.
- wbm_adr_o = start_adr + idx*BPW, computed modulo 2**WB_AW.
- idx increments on every ack and wraps to 0 after NW-1.

Burst length:
- blen = min(burst_size, NW - idx), computed in WAIT and held for the burst.

States:
- IDLE:
  - enable=1 and err_o=0 -> WAIT with idx=0.
- WAIT (cyc low):
  - enable=0 -> IDLE.
  - else fifo_cnt + blen <= 2**FIFO_AW (evaluated at FIFO_AW+2 bits, no overflow) -> BURST.
- BURST (cyc = stb = 1):
  - cti = 3'b111 on the last beat (beat count == blen-1, including blen=1); 3'b010 otherwise.
  - ack on the last beat:
    - if idx wraps and oneshot=1: -> IDLE, done_o pulses 1 cycle.
    - else if enable=0: -> IDLE.
    - else -> WAIT.
  - enable dropping mid-burst: the burst completes before stopping.
  - wbm_rty_i: no data taken; -> WAIT; re-issue from the same idx with blen recomputed.
  - wbm_err_i: no data taken; err_o set; -> ERROR.
  - Priority if several terminations are asserted together: err > rty > ack.
- ERROR (cyc low, busy_o high):
  - enable=0 -> IDLE and clear err_o.

Other rules:
- ack/err/rty received outside BURST are ignored.
- With the FIFO full, WAIT holds indefinitely with cyc low.

Optional Feature:
Macro WB_STREAM_WRITER_DMA_TIMEOUT_EN.
- Defined:
  - a counter runs in BURST and clears on any ack/err/rty;
  - on reaching TIMEOUT_CYCLES, treat as wbm_err_i: err_o set, ERROR state;
  - extra output port timeout_o (1 bit, sticky, cleared with err_o).
- Undefined: no counter, no timeout_o port; the master waits indefinitely.

Test Plan:
1. Continuous, 32-bit: start_adr=0x1000, buf_size=0x40, burst_size=4, FIFO empty, slave acks every cycle.
   -> 4 bursts of 4 beats at addresses 0x1000..0x103C, with cti 010,010,010,111 per burst; then wrap to 0x1000; fifo_wr count = ack count.
2. Clipped last burst, one-shot: buf_size=0x18 (6 words), burst_size=4, oneshot=1.
   -> bursts of 4 then 2 beats; second burst cti 010,111; done_o high exactly 1 cycle; busy_o 0 afterwards.
3. FIFO backpressure: FIFO_AW=4, fifo_cnt=13, burst_size=4.
   -> cyc stays 0; when fifo_cnt drops to 12, cyc rises the next cycle.
4. Retry then error: rty on beat 2 of idx 0..3.
   -> reissue starts at idx 2 with blen=2.
   Then err on the next beat -> err_o=1, cyc 0; enable=0 clears err_o and returns to IDLE.
5. Width and reset: WB_DW=64, sync reset pulse (low) mid-burst.
   -> address step is 8 bytes; cyc low the cycle after reset; idx=0; with enable high the block restarts at start_adr.
6. With WB_STREAM_WRITER_DMA_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never acks.
   -> timeout_o and err_o assert after 8 BURST cycles; cyc drops.
